// File: rtl/bitserial_logic_sequencer.sv
// Bit-serial sequencer for the shared 1-bit selectable logic unit.
// Presents one operand bit pair per clock (LSB first) to the unit and
// assembles the returned bits into a WIDTH-bit result register.
module bitserial_logic_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       op_sel,
    input  logic             op_neg_b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             lu_a,
    output logic             lu_b,
    output logic [2:0]       lu_select,
    output logic             lu_negate_b,
    input  logic             lu_result
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [2:0]       sel_r;
    logic             neg_r;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] result_next_s;
    logic             zero_r;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;
    logic             accept_s;

    // A request is taken only while idle; start in RUN/DONE is dropped.
    assign accept_s = start && (state_r == ST_IDLE);

    // Next-state selection for the IDLE -> RUN -> DONE -> IDLE cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register plus handshake flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s == ST_IDLE);
            busy_r  <= (state_next_s == ST_RUN);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    // Operand latch on accept and bit-index advance during RUN (no wrap).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= {WIDTH{1'b0}};
            b_r   <= {WIDTH{1'b0}};
            sel_r <= 3'b000;
            neg_r <= 1'b0;
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            a_r   <= op_a;
            b_r   <= op_b;
            sel_r <= op_sel;
            neg_r <= op_neg_b;
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_RUN) && (cnt_r != CNT_LAST)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Result assembly: cleared on accept, one bit inserted per RUN cycle.
    always_comb begin
        result_next_s = result_r;
        if (accept_s) begin
            result_next_s = {WIDTH{1'b0}};
        end else if (state_r == ST_RUN) begin
            result_next_s[cnt_r] = lu_result;
        end else begin
            result_next_s = result_r;
        end
    end

    // Result and zero flag registers; zero always tracks the stored result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r <= {WIDTH{1'b0}};
            zero_r   <= 1'b1;
        end else begin
            result_r <= result_next_s;
            zero_r   <= (result_next_s == {WIDTH{1'b0}});
        end
    end

    // Unit operand bits are only presented while running, else held low.
    always_comb begin
        lu_a = 1'b0;
        lu_b = 1'b0;
        if (state_r == ST_RUN) begin
            lu_a = a_r[cnt_r];
            lu_b = b_r[cnt_r];
        end else begin
            lu_a = 1'b0;
            lu_b = 1'b0;
        end
    end

    assign lu_select   = sel_r;
    assign lu_negate_b = neg_r;
    assign ready       = ready_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign result      = result_r;
    assign zero        = zero_r;

endmodule

// File: doc/bitserial_logic_sequencer.md
Name: bitserial_logic_sequencer

Overview:
Sequences the team's shared 1-bit selectable logic unit over WIDTH-bit operands, one bit per clock, LSB first.
- Accepts a word-level request (operands, op select, negate-b flag) through a start/ready handshake.
- Drives the unit's a/b/select/negate_b inputs and collects its 1-bit result into a WIDTH-bit result register.
- Sits between a word-level requester and the single combinational logic-unit instance, so the unit is reused instead of replicated WIDTH times.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
CNT_W, $clog2(WIDTH), width of the internal bit-index counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request strobe; accepted when start && ready
op_a  input  WIDTH  operand A, sampled on accept
op_b  input  WIDTH  operand B, sampled on accept
op_sel  input  3  op code passed to the unit (000 NOT a, 001 AND, 010 NAND, 011 OR, 100 NOR, 101 XOR, 110 XNOR, 111 const 0)
op_neg_b  input  1  negate-b flag passed to the unit
ready  output  1  high in IDLE only
busy  output  1  high in RUN
done  output  1  one-cycle pulse, result valid
result  output  WIDTH  assembled result, held until next accept
zero  output  1  result == 0, valid with done, held with result
lu_a  output  1  to unit input a
lu_b  output  1  to unit input b
lu_select  output  3  to unit select
lu_negate_b  output  1  to unit negate_b
lu_result  input  1  from unit result (combinational path from lu_* outputs)

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, cnt=0, a_reg=b_reg=0, sel_reg=000, neg_reg=0, result=0, zero=1, done=0, busy=0, ready=1.
- States:
  - IDLE: ready=1. On start at a rising edge, latch op_a/op_b/op_sel/op_neg_b, clear cnt and result, go to RUN.
  - RUN: busy=1. Each cycle, lu_a=a_reg[cnt] and lu_b=b_reg[cnt]. At the edge, result[cnt] <= lu_result.
    - If cnt==WIDTH-1, go to DONE; else cnt <= cnt+1.
  - DONE: done=1 for exactly one cycle, then go to IDLE. zero reflects the final result.
- lu_select and lu_negate_b are driven from sel_reg/neg_reg in all states; they are stable for the whole operation.
- lu_a and lu_b are 0 outside RUN.
- Latency: accept at edge E0 → WIDTH RUN cycles → done high in the cycle after edge E0+WIDTH. Next accept is possible at the edge ending the first IDLE cycle, giving a throughput of one op per WIDTH+2 cycles.
- start while busy or in DONE is ignored; it is not queued and latched values are unaffected.
- Input changes after accept have no effect on the current operation.
- result and zero change only at accept (cleared/updated during RUN) and are final at done.
  - result is intermediate (partially assembled) while busy=1.
  - Consumers sample result on done.
- op_sel=111: the unit returns 0, so result=0 and zero=1. This is not an error.
- Reset asserted mid-RUN: immediate return to reset values. No done is issued for the aborted op.
- cnt never exceeds WIDTH-1 and does not wrap while in RUN.

Test Plan:
(The bench connects the team's 1-bit selectable logic unit to the lu_* ports; WIDTH=8.)
1. op_a=0xA5, op_b=0x0F, op_sel=001, op_neg_b=0 → done 9 cycles after the accept edge, result=0x05, zero=0. lu_select=001 throughout.
2. Same operands, op_sel=001, op_neg_b=1 → result=0xA0. Then op_sel=101, op_neg_b=0 → result=0xAA. Then op_sel=110 → result=0x55.
3. op_a=0xA5, op_sel=000 (NOT a) → result=0x5A. Then op_sel=111 → result=0x00, zero=1. Then op_a=0xFF, op_b=0xFF, op_sel=100 → result=0x00, zero=1.
4. Start at accept, then pulse start with different operands on RUN cycle 3 → ignored. Result is that of the first op, exactly one done pulse, ready low from accept until after done.
5. rst_n low on RUN cycle 4 of an op → ready=1, busy=0, done=0, result=0, zero=1 immediately (asynchronous). No done follows. A new op started after release completes correctly.
6. Back-to-back: start held high continuously with op_sel=011, op_a=0x30, op_b=0x03 → successive done pulses spaced 10 cycles apart, result=0x33 each time.
